axi_read_master_mo: RTL and testbench

- Parametrised AXI4 read master; successor to the single-transfer read master.
- Accepts read commands on a valid/ready command port and issues them on AR with full VALID/READY compliance.
- Keeps up to MAX_OUTST bursts in flight and returns beats on a valid/ready response port with backpressure.
- Checks command legality and R-channel protocol (RID, RLAST); sits between a DMA/bus client and the AXI interconnect.

---
 rtl/axi_read_master_mo.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_read_master_mo.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_master_mo.sv
// AXI4 read master with up to MAX_OUTST single-ID bursts in flight, command
// legality checks, R-channel protocol checks and a one-entry response register.
module axi_read_master_mo #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [ID_W-1:0]                cmd_id,
  input  logic [ADDR_W-1:0]              cmd_addr,
  input  logic [7:0]                     cmd_len,
  input  logic [2:0]                     cmd_size,
  input  logic [1:0]                     cmd_burst,
  output logic                           cmd_err,
  output logic [ID_W-1:0]                ARID,
  output logic [ADDR_W-1:0]              ARADDR,
  output logic [7:0]                     ARLEN,
  output logic [2:0]                     ARSIZE,
  output logic [1:0]                     ARBURST,
  output logic                           ARVALID,
  input  logic                           ARREADY,
  input  logic [ID_W-1:0]                RID,
  input  logic [DATA_W-1:0]              RDATA,
  input  logic [1:0]                     RRESP,
  input  logic                           RLAST,
  input  logic                           RVALID,
  output logic                           RREADY,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [DATA_W-1:0]              rsp_data,
  output logic [1:0]                     rsp_resp,
  output logic                           rsp_last,
  output logic                           err_rid,
  output logic                           err_rlast,
  output logic                           err_unexp,
  output logic [$clog2(MAX_OUTST):0]     outst_cnt
);

  localparam int unsigned PTR_W    = $clog2(MAX_OUTST);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [2:0]  SIZE_MAX = 3'($clog2(DATA_W / 8));

  typedef enum logic { AR_IDLE, AR_VALID } ar_state_e;
  typedef enum logic { R_IDLE, R_BURST } r_state_e;

  ar_state_e ar_state_q, ar_state_d;
  r_state_e  r_state_q, r_state_d;

  logic [ID_W-1:0]   arid_q, arid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [7:0]        arlen_q, arlen_d;
  logic [2:0]        arsize_q, arsize_d;
  logic [1:0]        arburst_q, arburst_d;

  logic [ID_W-1:0]   fifo_id_q  [MAX_OUTST];
  logic [7:0]        fifo_len_q [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;

  logic [7:0]        beat_q, beat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              rsp_last_q, rsp_last_d;
  logic              cmd_err_q, cmd_err_d;
  logic              err_rid_q, err_rid_d;
  logic              err_rlast_q, err_rlast_d;
  logic              err_unexp_q, err_unexp_d;

  logic              fifo_empty, fifo_full;
  logic              accept, legal, push, pop, r_hs, fwd;
  logic [ADDR_W-1:0] size_mask;
  logic [16:0]       xfer_bytes, end_off;
  logic              burst_ok;
  logic [7:0]        exp_beat;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));

  // The 4 KB check uses the size-aligned start, matching where the last beat lands.
  always_comb begin
    size_mask  = (ADDR_W'(1) << cmd_size) - ADDR_W'(1);
    xfer_bytes = (17'(cmd_len) + 17'd1) << cmd_size;
    end_off    = 17'(cmd_addr[11:0] & ~size_mask[11:0]) + xfer_bytes;
    case (cmd_burst)
      2'd0:    burst_ok = (cmd_len <= 8'd15);
      2'd1:    burst_ok = (end_off <= 17'h1000);
      2'd2:    burst_ok = ((cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                           (cmd_len == 8'd7) || (cmd_len == 8'd15)) &&
                          ((cmd_addr & size_mask) == '0);
      default: burst_ok = 1'b0;
    endcase
    legal = (cmd_size <= SIZE_MAX) && burst_ok;
  end

  assign ARVALID   = (ar_state_q == AR_VALID);
  assign cmd_ready = !ARESET && (!ARVALID || ARREADY) && !fifo_full &&
                     (fifo_empty || (cmd_id == cur_id_q));
  assign accept    = cmd_valid && cmd_ready;
  assign push      = accept && legal;

  assign RREADY   = !ARESET && (!rsp_valid_q || rsp_ready);
  assign r_hs     = RVALID && RREADY;
  assign fwd      = r_hs && !fifo_empty;
  assign pop      = fwd && RLAST;
  assign exp_beat = (r_state_q == R_IDLE) ? 8'd0 : beat_q;

  always_comb begin
    ar_state_d  = ar_state_q;
    arid_d      = arid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    cur_id_d    = cur_id_q;
    r_state_d   = r_state_q;
    beat_d      = beat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_last_d  = rsp_last_q;
    cmd_err_d   = accept && !legal;
    err_rid_d   = 1'b0;
    err_rlast_d = 1'b0;
    err_unexp_d = r_hs && fifo_empty;

    if (push) begin
      ar_state_d = AR_VALID;
      arid_d     = cmd_id;
      araddr_d   = cmd_addr;
      arlen_d    = cmd_len;
      arsize_d   = cmd_size;
      arburst_d  = cmd_burst;
      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      cur_id_d   = cmd_id;
    end else if (ARVALID && ARREADY) begin
      ar_state_d = AR_IDLE;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (fwd) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = RID;
      rsp_data_d  = RDATA;
      rsp_resp_d  = RRESP;
      rsp_last_d  = RLAST;
      err_rid_d   = (RID != fifo_id_q[rd_ptr_q]);
      err_rlast_d = RLAST != (exp_beat == fifo_len_q[rd_ptr_q]);
      if (RLAST) begin
        beat_d    = '0;
        r_state_d = R_IDLE;
        rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      end else begin
        beat_d    = exp_beat + 8'd1;
        r_state_d = R_BURST;
      end
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ar_state_q  <= AR_IDLE;
      arid_q      <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      cur_id_q    <= '0;
      r_state_q   <= R_IDLE;
      beat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= '0;
      rsp_last_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      err_rid_q   <= 1'b0;
      err_rlast_q <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      ar_state_q  <= ar_state_d;
      arid_q      <= arid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      cur_id_q    <= cur_id_d;
      r_state_q   <= r_state_d;
      beat_q      <= beat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_last_q  <= rsp_last_d;
      cmd_err_q   <= cmd_err_d;
      err_rid_q   <= err_rid_d;
      err_rlast_q <= err_rlast_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_id_q[wr_ptr_q]  <= cmd_id;
      fifo_len_q[wr_ptr_q] <= cmd_len;
    end
  end

  assign ARID      = arid_q;
  assign ARADDR    = araddr_q;
  assign ARLEN     = arlen_q;
  assign ARSIZE    = arsize_q;
  assign ARBURST   = arburst_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_resp  = rsp_resp_q;
  assign rsp_last  = rsp_last_q;
  assign cmd_err   = cmd_err_q;
  assign err_rid   = err_rid_q;
  assign err_rlast = err_rlast_q;
  assign err_unexp = err_unexp_q;
  assign outst_cnt = cnt_q;

endmodule

// File: tb/tb_axi_read_master_mo.sv
// Directed bench for axi_read_master_mo: AR handshake, outstanding limit,
// ID ordering, illegal commands, response backpressure, protocol errors, reset.
module tb_axi_read_master_mo;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_id;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        cmd_err;
  logic [3:0]  ARID;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID, ARREADY;
  logic [3:0]  RID;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST, RVALID, RREADY;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_id;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        rsp_last;
  logic        err_rid, err_rlast, err_unexp;
  logic [2:0]  outst_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  axi_read_master_mo #(.ID_W(4), .ADDR_W(32), .DATA_W(64), .MAX_OUTST(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_err(cmd_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_last(rsp_last),
    .err_rid(err_rid), .err_rlast(err_rlast), .err_unexp(err_unexp), .outst_cnt(outst_cnt)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_size  = size;
    cmd_burst = burst;
  endtask

  task automatic set_beat(input logic [3:0] id, input logic [63:0] data, input logic last);
    RVALID = 1'b1;
    RID    = id;
    RDATA  = data;
    RLAST  = last;
    RRESP  = 2'd0;
  endtask

  initial begin
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
    cmd_size = '0; cmd_burst = '0; ARREADY = 1'b0; RID = '0; RDATA = '0; RRESP = '0;
    RLAST = 1'b0; RVALID = 1'b0; rsp_ready = 1'b1;
    tick(); tick();
    check("rst_arvalid", ARVALID, 0);
    check("rst_rready", RREADY, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_outst", outst_cnt, 0);
    check("rst_araddr", ARADDR, 0);
    check("rst_cmd_err", cmd_err, 0);
    ARESET = 1'b0;
    tick();

    // Single INCR burst with AR stalled two cycles
    set_cmd(4'd3, 32'h100, 8'd3, 3'd3, 2'd1);
    #1 check("t1_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t1_arvalid", ARVALID, 1);
      check("t1_araddr", ARADDR, 32'h100);
      check("t1_arid", ARID, 3);
      check("t1_arlen", ARLEN, 3);
      check("t1_arsize", ARSIZE, 3);
      check("t1_arburst", ARBURST, 1);
      if (i == 2) ARREADY = 1'b1;
      else check("t1_cmd_ready_stall", cmd_ready, 0);
      tick();
    end
    check("t1_arvalid_drop", ARVALID, 0);
    check("t1_outst1", outst_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      set_beat(4'd3, 64'hA0 + 64'(i), i == 3);
      if (i == 1) RRESP = 2'd2;
      #1 check("t1_rready", RREADY, 1);
      tick();
      check("t1_rsp_valid", rsp_valid, 1);
      check("t1_rsp_data", rsp_data, 64'hA0 + 64'(i));
      check("t1_rsp_last", rsp_last, (i == 3) ? 1 : 0);
      check("t1_rsp_resp", rsp_resp, (i == 1) ? 2 : 0);
      check("t1_err_rlast", err_rlast, 0);
      check("t1_outst", outst_cnt, (i == 3) ? 0 : 1);
    end
    RVALID = 1'b0;
    tick();
    check("t1_rsp_valid_clr", rsp_valid, 0);

    // Four back-to-back single-beat commands fill the tracker
    for (int i = 0; i < 4; i++) begin
      set_cmd(4'd1, 32'h200 + 32'(8 * i), 8'd0, 3'd3, 2'd1);
      #1 check("t2_cmd_ready", cmd_ready, 1);
      tick();
    end
    check("t2_outst4", outst_cnt, 4);
    check("t2_araddr_last", ARADDR, 32'h218);
    check("t2_arvalid", ARVALID, 1);
    set_cmd(4'd1, 32'h220, 8'd0, 3'd3, 2'd1);
    #1 check("t2_full_stall", cmd_ready, 0);
    tick();
    set_beat(4'd1, 64'hB0, 1'b1);
    #1 check("t2_full_stall_pop", cmd_ready, 0);
    tick();
    RVALID = 1'b0;
    check("t2_outst3", outst_cnt, 3);
    check("t2_rsp_data0", rsp_data, 64'hB0);
    #1 check("t2_cmd_ready_after_pop", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("t2_outst4_again", outst_cnt, 4);
    check("t2_araddr5", ARADDR, 32'h220);
    for (int i = 1; i < 5; i++) begin
      set_beat(4'd1, 64'hB0 + 64'(i), 1'b1);
      tick();
      check("t2_err_rid", err_rid, 0);
    end
    RVALID = 1'b0;
    check("t2_drained", outst_cnt, 0);
    tick();

    // New ID waits for the previous ID to drain
    set_cmd(4'd1, 32'h400, 8'd0, 3'd3, 2'd1);
    tick();
    set_cmd(4'd2, 32'h500, 8'd0, 3'd3, 2'd1);
    #1 check("t3_id_block", cmd_ready, 0);
    tick();
    check("t3_outst1", outst_cnt, 1);
    check("t3_id_block2", cmd_ready, 0);
    set_beat(4'd1, 64'hC0, 1'b1);
    tick();
    RVALID = 1'b0;
    check("t3_outst0", outst_cnt, 0);
    #1 check("t3_id_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("t3_arid2", ARID, 2);
    check("t3_outst1b", outst_cnt, 1);
    set_beat(4'd7, 64'hC1, 1'b1);
    tick();
    RVALID = 1'b0;
    check("t3_err_rid", err_rid, 1);
    check("t3_rsp_id_fwd", rsp_id, 7);
    check("t3_outst0b", outst_cnt, 0);
    tick();
    check("t3_err_rid_pulse", err_rid, 0);

    // Illegal commands are accepted, dropped and flagged
    set_cmd(4'd4, 32'hFF8, 8'd1, 3'd3, 2'd1);
    #1 check("t4_incr_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("t4_incr_cmd_err", cmd_err, 1);
    check("t4_incr_arvalid", ARVALID, 0);
    check("t4_incr_outst", outst_cnt, 0);
    tick();
    check("t4_cmd_err_pulse", cmd_err, 0);
    set_cmd(4'd4, 32'h100, 8'd2, 3'd3, 2'd2);
    tick();
    cmd_valid = 1'b0;
    check("t4_wrap_cmd_err", cmd_err, 1);
    check("t4_wrap_arvalid", ARVALID, 0);
    tick();
    check("t4_wrap_pulse", cmd_err, 0);
    set_cmd(4'd4, 32'hFF0, 8'd1, 3'd3, 2'd1);
    tick();
    cmd_valid = 1'b0;
    check("t4_incr_edge_legal", cmd_err, 0);
    check("t4_incr_edge_arvalid", ARVALID, 1);
    set_beat(4'd4, 64'hD0, 1'b0);
    tick();
    set_beat(4'd4, 64'hD1, 1'b1);
    tick();
    RVALID = 1'b0;
    check("t4_drain", outst_cnt, 0);

    // Response backpressure, then an early RLAST
    set_cmd(4'd5, 32'h300, 8'd3, 3'd3, 2'd1);
    tick();
    cmd_valid = 1'b0;
    set_beat(4'd5, 64'hE0, 1'b0);
    tick();
    rsp_ready = 1'b0;
    set_beat(4'd5, 64'hE1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 check("t5_rready_low", RREADY, 0);
      tick();
      check("t5_rsp_hold", rsp_data, 64'hE0);
    end
    rsp_ready = 1'b1;
    #1 check("t5_rready_high", RREADY, 1);
    tick();
    check("t5_rsp_e1", rsp_data, 64'hE1);
    set_beat(4'd5, 64'hE2, 1'b1);
    tick();
    RVALID = 1'b0;
    check("t5_err_rlast", err_rlast, 1);
    check("t5_rsp_last", rsp_last, 1);
    check("t5_pop", outst_cnt, 0);
    tick();
    check("t5_err_rlast_pulse", err_rlast, 0);

    // Reset mid-burst, then a stray beat
    set_cmd(4'd6, 32'h600, 8'd3, 3'd3, 2'd1);
    tick();
    cmd_valid = 1'b0;
    set_beat(4'd6, 64'hF0, 1'b0);
    tick();
    RVALID = 1'b0;
    check("t6_beat1", rsp_data, 64'hF0);
    ARESET = 1'b1;
    tick();
    check("t6_rst_rsp_valid", rsp_valid, 0);
    check("t6_rst_rsp_data", rsp_data, 0);
    check("t6_rst_outst", outst_cnt, 0);
    check("t6_rst_arvalid", ARVALID, 0);
    check("t6_rst_araddr", ARADDR, 0);
    check("t6_rst_rready", RREADY, 0);
    ARESET = 1'b0;
    tick();
    set_beat(4'd6, 64'hF1, 1'b0);
    #1 check("t6_unexp_rready", RREADY, 1);
    tick();
    RVALID = 1'b0;
    check("t6_err_unexp", err_unexp, 1);
    check("t6_unexp_rsp_valid", rsp_valid, 0);
    tick();
    check("t6_err_unexp_pulse", err_unexp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
